// File: rtl/ysyx_210184_pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM states and redirect-source selection.
package ysyx_210184_pipe_ctrl_pkg;

  localparam int REG_W = 64;

  typedef enum logic [1:0] {
    PCTL_RUN   = 2'd0,
    PCTL_REDIR = 2'd1,
    PCTL_MWAIT = 2'd2
  } pctl_state_e;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_MTVEC = 2'd1,
    SEL_MEPC  = 2'd2,
    SEL_BR    = 2'd3
  } pc_sel_e;

  // Trap entry beats trap return, which beats an ordinary control transfer.
  function automatic pc_sel_e redirect_sel(input logic ecall, input logic mret,
                                           input logic br);
    if (ecall)     return SEL_MTVEC;
    else if (mret) return SEL_MEPC;
    else if (br)   return SEL_BR;
    else           return SEL_NONE;
  endfunction

  function automatic logic [REG_W-1:0] pick_pc(input pc_sel_e sel,
                                               input logic [REG_W-1:0] mtvec,
                                               input logic [REG_W-1:0] mepc,
                                               input logic [REG_W-1:0] br);
    case (sel)
      SEL_MTVEC: return mtvec;
      SEL_MEPC:  return mepc;
      default:   return br;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_210184_pipe_ctrl_cnt.sv
// Parameterised up-counter with synchronous clear; SAT selects saturate vs wrap.
module ysyx_210184_pctl_cnt #(
  parameter int W   = 32,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (!(SAT && (&cnt_q))) cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ysyx_210184_pipe_ctrl.sv
// Pipeline sequencer: turns hazard/redirect events into per-stage stall/flush
// controls, a single redirect PC for IF, a memory-wait watchdog and perf counters.
module ysyx_210184_pipe_ctrl
  import ysyx_210184_pipe_ctrl_pkg::*;
#(
  parameter int WD_W  = 16,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_use_i,
  input  logic              br_taken_i,
  input  logic              jump_i,
  input  logic [REG_W-1:0]  br_target_i,
  input  logic              ecall_i,
  input  logic              mret_i,
  input  logic [REG_W-1:0]  mtvec_i,
  input  logic [REG_W-1:0]  mepc_i,
  input  logic              if_busy_i,
  input  logic              mem_busy_i,
  output logic              stall_if_o,
  output logic              stall_id_o,
  output logic              stall_ex_o,
  output logic              stall_mem_o,
  output logic              flush_id_o,
  output logic              flush_ex_o,
  output logic              redirect_valid_o,
  output logic [REG_W-1:0]  redirect_pc_o,
  output logic              wd_err_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output pctl_state_e       state_o
);

  localparam logic [WD_W-1:0] WD_PRE = {{(WD_W-1){1'b1}}, 1'b0};

  pctl_state_e      state_q, state_d;
  logic [REG_W-1:0] pc_hold_q, pc_hold_d;
  logic             wd_err_q, wd_err_d;
  logic [WD_W-1:0]  wd_cnt;
  logic             wd_inc;
  logic             flush_acc;
  pc_sel_e          sel;

  // Handshake: redirect_valid_o is a one-cycle pulse with no ready; if_busy_i
  // acts as not-ready and holds the FSM in REDIRECT until IF can take the PC.
  always_comb begin
    state_d          = state_q;
    pc_hold_d        = pc_hold_q;
    stall_if_o       = 1'b0;
    stall_id_o       = 1'b0;
    stall_ex_o       = 1'b0;
    stall_mem_o      = 1'b0;
    flush_id_o       = 1'b0;
    flush_ex_o       = 1'b0;
    redirect_valid_o = 1'b0;
    flush_acc        = 1'b0;
    sel              = redirect_sel(ecall_i, mret_i, br_taken_i | jump_i);
    if (rst) begin
      case (state_q)
        PCTL_REDIR: begin
          // Events seen here belong to squashed instructions and are dropped.
          if (!if_busy_i) begin
            redirect_valid_o = 1'b1;
            state_d          = PCTL_RUN;
          end else begin
            stall_if_o = 1'b1;
            flush_id_o = 1'b1;
          end
          if (mem_busy_i) stall_mem_o = 1'b1;
        end
        default: begin
          // MEM_WAIT with the bus idle behaves exactly like RUN so a held
          // branch is accepted in the cycle the stall lifts.
          state_d = PCTL_RUN;
          if (mem_busy_i) begin
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            stall_ex_o  = 1'b1;
            stall_mem_o = 1'b1;
            state_d     = PCTL_MWAIT;
          end else if (sel != SEL_NONE) begin
            stall_if_o = 1'b1;
            flush_id_o = 1'b1;
            flush_ex_o = 1'b1;
            flush_acc  = 1'b1;
            pc_hold_d  = pick_pc(sel, mtvec_i, mepc_i, br_target_i);
            state_d    = PCTL_REDIR;
          end else if (load_use_i) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
          end
        end
      endcase
    end
  end

  assign wd_inc   = mem_busy_i && (state_q != PCTL_REDIR);
  assign wd_err_d = wd_err_q | (wd_inc && (wd_cnt == WD_PRE));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= PCTL_RUN;
      pc_hold_q <= '0;
      wd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_hold_q <= pc_hold_d;
      wd_err_q  <= wd_err_d;
    end
  end

  ysyx_210184_pctl_cnt #(.W(WD_W), .SAT(1'b1)) u_wd (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!wd_inc),
    .inc_i (wd_inc),
    .cnt_o (wd_cnt)
  );

  ysyx_210184_pctl_cnt #(.W(CNT_W), .SAT(1'b0)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (1'b0),
    .inc_i (stall_if_o),
    .cnt_o (stall_cnt_o)
  );

  ysyx_210184_pctl_cnt #(.W(CNT_W), .SAT(1'b0)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (1'b0),
    .inc_i (flush_acc),
    .cnt_o (flush_cnt_o)
  );

  assign redirect_pc_o = pc_hold_q;
  assign wd_err_o      = wd_err_q;
  assign state_o       = state_q;

endmodule
